// File: rtl/waveform_buffer.sv
// waveform_buffer: circular store of decimated signed samples, replayed one
// sample per pixel column so the newest sample sits at the right edge of the
// trace. Writes follow the sample strobe; reads follow the pixel scan.
module waveform_buffer #(
    parameter int DEPTH    = 1024,
    parameter int DECIMATE = 4,
    parameter int DATA_W   = 9
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic signed [DATA_W-1:0] sample_in,
    input  logic                     sample_valid,
    input  logic                     freeze,
    input  logic                     frame_start,
    input  logic [10:0]              hcount,
    input  logic [9:0]               vcount,
    output logic signed [DATA_W-1:0] signal_out,
    output logic                     signal_valid,
    output logic [10:0]              hcount_out,
    output logic [9:0]               vcount_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;

    logic signed [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] base;
    logic [AW:0]   fill;
    logic [AW:0]   fill_f;
    logic [DW-1:0] dec_cnt;

    logic          accept;
    logic          wr_en;
    logic [AW-1:0] rd_addr;
    logic          col_ok;

    logic signed [DATA_W-1:0] rd_data_p1;
    logic                     vld_p1;

    // A column is shown only if it lies inside the trace and within the
    // newest fill_f columns; older columns would expose unwritten RAM.
    function automatic logic col_visible(input logic [10:0] col, input logic [AW:0] cnt);
        int c;
        c = int'(col);
        return (c < DEPTH) && (c >= DEPTH - int'(cnt));
    endfunction

    // Frozen strobes are ignored entirely, so the decimation phase is kept.
    assign accept  = reset_n && sample_valid && !freeze;
    assign wr_en   = accept && (dec_cnt == '0);
    assign rd_addr = base + hcount[AW-1:0];
    assign col_ok  = col_visible(hcount, fill_f);

    // Write-side bookkeeping: decimation phase, write pointer and fill level.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            dec_cnt <= '0;
            wr_ptr  <= '0;
            fill    <= '0;
        end else begin
            if (accept) begin
                dec_cnt <= (dec_cnt == DW'(DECIMATE - 1)) ? '0 : dec_cnt + DW'(1);
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (fill != (AW+1)'(DEPTH)) begin
                    fill <= fill + (AW+1)'(1);
                end
            end
        end
    end

    // Per-frame snapshot of the oldest address and valid count; uses the
    // pre-write values so a coincident write lands in the next frame.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            base   <= '0;
            fill_f <= '0;
        end else if (frame_start) begin
            base   <= wr_ptr;
            fill_f <= fill;
        end
    end

    // Sample RAM write port.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= sample_in;
        end
    end

    // ---- stage p0 -> p1: RAM read (read-first) and column qualification ----
    // Raw RAM read; a same-cycle write to this address returns the old word.
    always_ff @(posedge clock) begin
        rd_data_p1 <= mem[rd_addr];
    end

    // Valid flag and scan coordinates travel alongside the read data.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            vld_p1     <= 1'b0;
            hcount_out <= '0;
            vcount_out <= '0;
        end else begin
            vld_p1     <= col_ok;
            hcount_out <= hcount;
            vcount_out <= vcount;
        end
    end

    // ---- stage p1: output gating ----
    assign signal_valid = vld_p1;
    assign signal_out   = vld_p1 ? rd_data_p1 : '0;

endmodule

// File: tb/tb_waveform_buffer.sv
// Bench for waveform_buffer: two instances (DECIMATE=4 and DECIMATE=1) share
// all stimulus; expected scan results are queued as columns are driven and a
// monitor compares them against the aligned outputs.
module tb_waveform_buffer;

    localparam int P_DARK  = 0;
    localparam int P_PART  = 1;
    localparam int P_WRAP  = 2;
    localparam int P_PRE   = 3;
    localparam int P_77    = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic              reset_n;
    logic signed [8:0] sample_in;
    logic              sample_valid;
    logic              freeze;
    logic              frame_start;
    logic [10:0]       hcount;
    logic [9:0]        vcount;

    logic signed [8:0] so4, so1;
    logic              sv4, sv1;
    logic [10:0]       ho4, ho1;
    logic [9:0]        vo4, vo1;

    waveform_buffer #(.DEPTH(1024), .DECIMATE(4)) u4 (
        .clock(clock), .reset_n(reset_n), .sample_in(sample_in),
        .sample_valid(sample_valid), .freeze(freeze), .frame_start(frame_start),
        .hcount(hcount), .vcount(vcount), .signal_out(so4),
        .signal_valid(sv4), .hcount_out(ho4), .vcount_out(vo4)
    );

    waveform_buffer #(.DEPTH(1024), .DECIMATE(1)) u1 (
        .clock(clock), .reset_n(reset_n), .sample_in(sample_in),
        .sample_valid(sample_valid), .freeze(freeze), .frame_start(frame_start),
        .hcount(hcount), .vcount(vcount), .signal_out(so1),
        .signal_valid(sv1), .hcount_out(ho1), .vcount_out(vo1)
    );

    typedef struct {
        logic [10:0]       h;
        logic [9:0]        v;
        logic              vld4;
        logic signed [8:0] d4;
        logic              vld1;
        logic signed [8:0] d1;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   passed = 0;
    logic scan   = 1'b0;
    logic scan_d = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    // Hand-derived expected display per scenario.
    function automatic void expect_col(input int ph, input int c,
                                       output logic v4, output logic signed [8:0] d4,
                                       output logic v1, output logic signed [8:0] d1);
        v4 = 1'b0; d4 = '0; v1 = 1'b0; d1 = '0;
        case (ph)
            P_PART: begin
                if (c >= 1014) begin v4 = 1'b1; d4 = 9'((c - 1014) * 4); end
                if (c >= 984)  begin v1 = 1'b1; d1 = 9'(c - 984); end
            end
            P_WRAP: begin
                if (c >= 749) begin v4 = 1'b1; d4 = 9'(((c - 749) * 4) % 256); end
                v1 = 1'b1; d1 = 9'((76 + c) % 256);
            end
            P_PRE: begin
                if (c >= 748) begin
                    v4 = 1'b1;
                    if (c == 1023) d4 = 9'(-5);
                    else d4 = 9'(((c - 748) * 4) % 256);
                end
                v1 = 1'b1;
                if (c == 1023) d1 = 9'(-5);
                else d1 = 9'((77 + c) % 256);
            end
            P_77: begin
                if (c == 1023) begin v4 = 1'b1; d4 = 9'(77); v1 = 1'b1; d1 = 9'(77); end
            end
            default: ;
        endcase
    endfunction

    always @(posedge clock) scan_d <= scan;

    // Monitor: one queued expectation per scanned column.
    always @(negedge clock) begin
        if (scan_d) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'(sb.size()), 64'd1);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("u4 col%0d row%0d", mon_e.h, mon_e.v),
                      64'({ho4, vo4, sv4, so4}),
                      64'({mon_e.h, mon_e.v, mon_e.vld4, mon_e.d4}));
                check($sformatf("u1 col%0d row%0d", mon_e.h, mon_e.v),
                      64'({ho1, vo1, sv1, so1}),
                      64'({mon_e.h, mon_e.v, mon_e.vld1, mon_e.d1}));
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_fs;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic write_samples(input int n0, input int n1);
        for (int n = n0; n <= n1; n++) begin
            sample_valid = 1'b1;
            sample_in    = 9'(n % 256);
            tick();
        end
        sample_valid = 1'b0;
    endtask

    task automatic scan_line(input int v, input int c0, input int c1, input int ph, input bit wr0);
        exp_t e;
        logic v4, v1;
        logic signed [8:0] d4, d1;
        for (int c = c0; c <= c1; c++) begin
            hcount = 11'(c);
            vcount = 10'(v);
            scan   = 1'b1;
            sample_valid = wr0 && (c == c0);
            sample_in    = sample_valid ? 9'(-5) : 9'(0);
            expect_col(ph, c, v4, d4, v1, d1);
            e.h = 11'(c); e.v = 10'(v);
            e.vld4 = v4; e.d4 = d4; e.vld1 = v1; e.d1 = d1;
            sb.push_back(e);
            tick();
        end
        scan = 1'b0;
        sample_valid = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; sample_in = '0; sample_valid = 1'b0; freeze = 1'b0;
        frame_start = 1'b0; hcount = 11'd5; vcount = 10'd7;
        tick();
        tick();
        check("rst so4", 64'(so4), 64'd0);
        check("rst sv4", 64'(sv4), 64'd0);
        check("rst ho4", 64'(ho4), 64'd0);
        check("rst vo4", 64'(vo4), 64'd0);
        check("rst so1", 64'(so1), 64'd0);
        check("rst sv1", 64'(sv1), 64'd0);
        check("rst ho1", 64'(ho1), 64'd0);
        check("rst vo1", 64'(vo1), 64'd0);
        reset_n = 1'b1;
        tick();

        // Empty buffer: everything dark.
        pulse_fs();
        scan_line(10, 0, 1023, P_DARK, 1'b0);

        // Partial fill with 40 samples 0..39.
        write_samples(0, 39);
        pulse_fs();
        scan_line(20, 0, 1023, P_PART, 1'b0);

        // Continue to 1100 samples total: wrap-around.
        write_samples(40, 1099);
        pulse_fs();
        scan_line(30, 0, 1023, P_WRAP, 1'b0);

        // Freeze rises together with the first dropped strobe.
        freeze = 1'b1;
        for (int i = 0; i < 50; i++) begin
            sample_valid = 1'b1;
            sample_in    = 9'(-100);
            tick();
        end
        sample_valid = 1'b0;
        freeze = 1'b0;
        tick();
        // Same frame as before; column 0 read collides with a write of -5.
        pulse_fs();
        scan_line(40, 0, 1023, P_WRAP, 1'b1);

        // Full frame, reset during line 300.
        pulse_fs();
        scan_line(299, 0, 1023, P_PRE, 1'b0);
        scan_line(300, 0, 511, P_PRE, 1'b0);
        reset_n = 1'b0;
        hcount  = 11'd512;
        tick();
        reset_n = 1'b1;
        scan_line(300, 512, 1023, P_DARK, 1'b0);
        pulse_fs();
        scan_line(0, 0, 1023, P_DARK, 1'b0);

        // Write of 77 coincident with frame_start.
        frame_start  = 1'b1;
        sample_valid = 1'b1;
        sample_in    = 9'(77);
        tick();
        frame_start  = 1'b0;
        sample_valid = 1'b0;
        scan_line(1, 0, 1023, P_DARK, 1'b0);
        pulse_fs();
        scan_line(2, 0, 1023, P_77, 1'b0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
